// File: rtl/du_reg_dumper.sv
// rtl/du_reg_dumper.sv - streams the 32-entry register file (plus PC when DU_DUMP_PC_EN is defined) out as bytes, MSB first
module du_reg_dumper (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    output logic [4:0]  o_du_reg_addr,
    input  logic [31:0] i_du_reg_data,
    input  logic [31:0] i_pc,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_busy,
    output logic        o_done
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LATCH    = 3'd1;
    localparam logic [2:0] S_SEND     = 3'd2;
`ifdef DU_DUMP_PC_EN
    localparam logic [2:0] S_PC_LATCH = 3'd3;
`endif
    localparam logic [2:0] S_DONE     = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [31:0] shift_q, shift_d;
    logic [1:0]  cnt_q, cnt_d;

`ifdef DU_DUMP_PC_EN
    // Set once the PC word is loaded so the last byte of it terminates the dump.
    logic pc_phase_q, pc_phase_d;
`else
    logic unused_pc;
    assign unused_pc = ^i_pc;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
`ifdef DU_DUMP_PC_EN
        pc_phase_d = pc_phase_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    idx_d   = 5'd0;
                    state_d = S_LATCH;
`ifdef DU_DUMP_PC_EN
                    pc_phase_d = 1'b0;
`endif
                end
            end
            S_LATCH: begin
                shift_d = i_du_reg_data;
                cnt_d   = 2'd0;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (i_tx_ready) begin
                    shift_d = {shift_q[23:0], 8'h00};
                    cnt_d   = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
`ifdef DU_DUMP_PC_EN
                        if (pc_phase_q) begin
                            state_d = S_DONE;
                        end else if (idx_q != 5'd31) begin
                            idx_d   = idx_q + 5'd1;
                            state_d = S_LATCH;
                        end else begin
                            state_d = S_PC_LATCH;
                        end
`else
                        if (idx_q != 5'd31) begin
                            idx_d   = idx_q + 5'd1;
                            state_d = S_LATCH;
                        end else begin
                            state_d = S_DONE;
                        end
`endif
                    end
                end
            end
`ifdef DU_DUMP_PC_EN
            S_PC_LATCH: begin
                shift_d    = i_pc;
                cnt_d      = 2'd0;
                pc_phase_d = 1'b1;
                state_d    = S_SEND;
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            idx_q   <= 5'd0;
            shift_q <= 32'd0;
            cnt_q   <= 2'd0;
`ifdef DU_DUMP_PC_EN
            pc_phase_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
`ifdef DU_DUMP_PC_EN
            pc_phase_q <= pc_phase_d;
`endif
        end
    end

    assign o_du_reg_addr = idx_q;
    assign o_tx_data     = shift_q[31:24];
    assign o_tx_valid    = (state_q == S_SEND);
    assign o_busy        = (state_q != S_IDLE);
    assign o_done        = (state_q == S_DONE);

endmodule
